// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC register and provides PC+4.
// Optional FETCH_MISALIGN_CHECK_EN adds a registered MisalignF flag for the loaded PC.
module rv32i_fetch_stage #(
    parameter int unsigned      DPW      = 32,
    parameter logic [DPW-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           FlushF,
    input  logic           stallF,
    input  logic [DPW-1:0] PCNext,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic           MisalignF,
`endif
    output logic [DPW-1:0] PCF,
    output logic [DPW-1:0] PCPlus4F
);

    // Redirect beats stall; an unasserted load leaves PCF untouched even if PCNext is X.
    logic load_pc;

    always_comb begin
        load_pc = FlushF || !stallF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCF <= RESET_PC;
        end else if (load_pc) begin
            PCF <= PCNext;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MisalignF <= 1'b0;
        end else if (load_pc) begin
            MisalignF <= |PCNext[1:0];
        end
    end
`endif

    always_comb begin
        PCPlus4F = PCF + DPW'(4);
    end

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Self-checking bench for rv32i_fetch_stage: directed cases plus randomized traffic vs. a reference model.
// Covers MisalignF when FETCH_MISALIGN_CHECK_EN is defined.
module tb_rv32i_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        FlushF = 1'b0;
    logic        stallF = 1'b0;
    logic [31:0] PCNext = 32'h0;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        MisalignF;
`endif

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    rv32i_fetch_stage #(.DPW(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .FlushF   (FlushF),
        .stallF   (stallF),
        .PCNext   (PCNext),
`ifdef FETCH_MISALIGN_CHECK_EN
        .MisalignF(MisalignF),
`endif
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F)
    );

    always #5 clk = ~clk;

    // Reference model: PC value the fetch stage must hold, plus the alignment flag of that value.
    logic [31:0] exp_pc = RST_PC;
    logic        exp_mis = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_pc  = RST_PC;
            exp_mis = 1'b0;
        end else if (FlushF === 1'b1 || stallF === 1'b0) begin
            exp_pc  = PCNext;
            exp_mis = (PCNext % 4) != 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("model_pcf", PCF, exp_pc);
            chk("model_pcplus4", PCPlus4F, exp_pc + 32'd4);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("model_misalign", {31'b0, MisalignF}, {31'b0, exp_mis});
`endif
        end
    end

    // Drive controls away from edges, wait through one rising edge, settle 1 time unit.
    task automatic apply(input logic f, input logic s, input logic [31:0] nxt);
        FlushF = f;
        stallF = s;
        PCNext = nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Asynchronous reset, checked before the first clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset_pcf", PCF, 32'h0);
        chk("reset_pcplus4", PCPlus4F, 32'h4);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("reset_misalign", {31'b0, MisalignF}, 32'h0);
`endif
        @(posedge clk);
        #1;
        chk("reset_held_pcf", PCF, 32'h0);
        rst = 1'b0;
        run_cmp = 1'b1;

        apply(1'b0, 1'b0, 32'h0000_1000);
        chk("load_pcf", PCF, 32'h0000_1000);
        chk("load_pcplus4", PCPlus4F, 32'h0000_1004);

        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 32'hDEAD_BEE0);
            chk("stall_pcf", PCF, 32'h0000_1000);
        end

        apply(1'b1, 1'b1, 32'h0000_2000);
        chk("flush_over_stall_pcf", PCF, 32'h0000_2000);
        apply(1'b1, 1'b0, 32'h0000_3000);
        chk("flush_pcf", PCF, 32'h0000_3000);

        apply(1'b0, 1'b0, 32'hFFFF_FFFC);
        chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PCPlus4F, 32'h0);

        apply(1'b0, 1'b1, 32'h1234_5678);
        chk("prestall_pcf", PCF, 32'hFFFF_FFFC);
        rst = 1'b1;
        #1;
        chk("async_rst_pcf", PCF, 32'h0);
        chk("async_rst_pcplus4", PCPlus4F, 32'h4);
        #1 rst = 1'b0;
        apply(1'b0, 1'b0, 32'h0000_0040);
        chk("resume_pcf", PCF, 32'h0000_0040);

        apply(1'b0, 1'b0, 32'h0000_0103);
        chk("unaligned_pcf", PCF, 32'h0000_0103);

        apply(1'b0, 1'b1, 32'hxxxx_xxxx);
        chk("x_stall_pcf", PCF, 32'h0000_0103);

`ifdef FETCH_MISALIGN_CHECK_EN
        apply(1'b0, 1'b0, 32'h0000_1002);
        chk("mis_set", {31'b0, MisalignF}, 32'h1);
        apply(1'b0, 1'b1, 32'h0000_1004);
        chk("mis_stall_hold", {31'b0, MisalignF}, 32'h1);
        apply(1'b0, 1'b0, 32'h0000_1004);
        chk("mis_clear", {31'b0, MisalignF}, 32'h0);
`endif

        // Randomized traffic, including X on PCNext during plain stalls and async reset pulses.
        for (int i = 0; i < 600; i++) begin
            logic f, s;
            logic [31:0] nxt;
            f = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 2) == 0);
            nxt = $urandom;
            if (!f && s && $urandom_range(0, 3) == 0) nxt = 32'hxxxx_xxxx;
            apply(f, s, nxt);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_async_rst_pcf", PCF, RST_PC);
                rst = 1'b0;
            end
        end

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
